design06_sched: RTL
===================

# design06_sched

Two-client scheduler for the shared `mkDesign_06` datapath. Each client posts one operand set (a, b, c, d). The block grants the datapath round-robin and sequences the full `start` → `result` → `check` method chain. It then returns the captured `result` and `check` values to the owning client through a per-client response slot. It sits between the two consumer pipelines and the single `mkDesign_06` instance.

## Interface
- `W`, 10: operand/result width; must match the datapath.
- `TIMEOUT`, 255: watchdog limit in cycles; used only with the watchdog compiled in; range 1..255.
- `CLK`  in  1  clock.
- `RST_N`  in  1  asynchronous active-low reset.
- `req0_valid`, `req1_valid`  in  1  client request, held until acked.
- `req0_ack`, `req1_ack`  out  1  one-cycle grant pulse; operands captured this cycle.
- `reqN_a`, `reqN_b`, `reqN_c`, `reqN_d`  in  W each  client operands.
- `resp0_valid`, `resp1_valid`  out  1  response slot full.
- `resp0_ack`, `resp1_ack`  in  1  client consumes response.
- `respN_result`, `respN_check`  out  W each  captured datapath outputs.
- `respN_err`  out  1  watchdog abort flag.
- `start_st$a`, `start_st$b`  out  W each  start arguments.
- `EN_start`  out  1  start enable.
- `RDY_start`  in  1  start ready.
- `result_st$c`  out  W  result argument.
- `result`  in  W  result value.
- `RDY_result`  in  1  result ready.
- `check_st$d`  out  W  check argument.
- `EN_check`  out  1  check enable.
- `check`  in  W  check value.
- `RDY_check`  in  1  check ready.

## Operation
- States: IDLE, START, WAIT_RES, CHECK. Also holds `owner` (1 bit), `prio` (1 bit), operand registers, and per-client response slots.
- **IDLE:** client i is eligible when `reqi_valid && !respi_valid`.
  - One eligible client: grant it.
  - Both eligible: grant client `prio`.
  - On grant: `reqi_ack`=1 (combinational, this cycle only). Latch a/b/c/d and `owner`=i. Set `prio`=~i. Next state START.
- **START:**
  - `start_st$a`/`start_st$b` drive the latched a/b.
  - `EN_start` = `RDY_start` (combinational, only in START).
  - On fire, next state WAIT_RES.
- **WAIT_RES:**
  - `result_st$c` drives latched c.
  - When `RDY_result`=1, latch `result`. Next state CHECK.
- **CHECK:**
  - `check_st$d` drives latched d.
  - `EN_check` = `RDY_check`.
  - On fire, write latched result and `check` into slot `owner`. Set `resp_owner_valid`=1, err=0. Next state IDLE.
- Response slot:
  - Contents are stable while valid.
  - `respi_ack` with valid clears valid at the next edge.
  - `respi_ack` without valid is ignored.
  - A slot fill and an ack for the other slot in the same cycle are independent.
- A client with a full slot is never granted. The other client may still be served.
- `EN_start` and `EN_check` are never high outside their state. Only one datapath operation is in flight.
- Datapath argument outputs hold their last latched values in all states.
- Reset (async, `RST_N`=0): state IDLE. `prio`=0, `owner`=0. All operand and response registers are 0, all `respi_valid`=0, all `respi_err`=0. `EN_start`, `EN_check`, and both acks are 0.
- Reset mid-operation abandons the in-flight operation; no response is produced.

## Timing
- Grant at cycle T with all RDY inputs high:
  - `EN_start` at T+1.
  - `result` sampled at T+2.
  - `EN_check` at T+3.
  - `respi_valid` high from T+4.
- The earliest next grant is at T+4 (IDLE).
- Each RDY_* low cycle adds one cycle of stall in its state.
- Back-to-back service of both clients: second ack at T+4, second response at T+8.

## Configuration
- Macro: `DESIGN06_SCHED_WATCHDOG_EN`.
- **Defined:**
  - An 8-bit counter clears on entry to START and counts each cycle in START, WAIT_RES and CHECK.
  - If it reaches `TIMEOUT` before the state's handshake completes, the operation is aborted: slot `owner` gets result=0, check=0, err=1, valid=1.
  - Next state is IDLE, and `EN_*` stay low in the abort cycle.
  - Handshake completion and timeout in the same cycle: completion wins.
- **Undefined:** no counter. The block waits indefinitely in each state, and `respN_err` is tied 0.

## Test plan
- Single request: client 0 with a=3, b=5, c=7, d=9, all RDY high, datapath result=0x12, check=0x34. Required: ack0 at T, `EN_start` at T+1 with `start_st$a`=3 and `start_st$b`=5, `resp0_valid` at T+4 with result=0x12, check=0x34.
- Simultaneous requests after reset: ack0 first (`prio`=0), then ack1 at T+4. A third round with both clients valid grants client 0 again only after client 1 has been served.
- Slot full: do not ack resp0 and reassert req0 together with req1. Required: only client 1 is granted; client 0 is granted in the IDLE cycle after `resp0_ack`.
- Stall: `RDY_start` low for 3 cycles and `RDY_check` low for 2 cycles. Required: `EN_start`/`EN_check` stay 0 while low, and the response arrives at T+9.
- Reset mid-op: drop `RST_N` in WAIT_RES. Required: all outputs at reset values immediately, state IDLE, no response after release.
- Watchdog (macro on, `TIMEOUT`=4): hold `RDY_result` low. Required: `resp0_valid`=1, err=1, result=0, check=0, then IDLE.

Source files
------------

// File: rtl/design06_sched.sv
// -----------------------------------------------------------------------------
// design06_sched
//   Two-client round-robin scheduler for one shared mkDesign_06 datapath.
//   A granted client's operands are latched. The start -> result -> check
//   method chain then runs, and the captured result/check pair is returned
//   through the owning client's response slot.
//
//   Optional feature macro: DESIGN06_SCHED_WATCHDOG_EN
//     defined   : an 8-bit watchdog aborts an operation after TIMEOUT busy
//                 cycles. The owning slot is filled with err=1 and zeroed data.
//     undefined : there is no watchdog. The block waits indefinitely in each
//                 state, and respN_err is tied 0.
//
// Ports
//   CLK, RST_N                       clock, async active-low reset
//   reqN_valid / reqN_ack            client request / one-cycle grant pulse
//   reqN_a..reqN_d                   client operands (W bits)
//   respN_valid / respN_ack          response slot full / client consume
//   respN_result, respN_check        captured datapath outputs
//   respN_err                        watchdog abort flag
//   start_st_a, start_st_b, EN_start, RDY_start       datapath start method
//   result_st_c, result, RDY_result                    datapath result method
//   check_st_d, EN_check, check, RDY_check             datapath check method
//
// States
//   S_IDLE     | arbitrate eligible clients, latch operands of the winner
//   S_START    | drive a/b, fire start when RDY_start
//   S_WAIT_RES | drive c, capture result when RDY_result
//   S_CHECK    | drive d, fire check when RDY_check, fill owner's slot
// -----------------------------------------------------------------------------
module design06_sched #(
    parameter int W       = 10,
    parameter int TIMEOUT = 255
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ack,
    output logic         req1_ack,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req0_c,
    input  logic [W-1:0] req0_d,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [W-1:0] req1_c,
    input  logic [W-1:0] req1_d,
    output logic         resp0_valid,
    output logic         resp1_valid,
    input  logic         resp0_ack,
    input  logic         resp1_ack,
    output logic [W-1:0] resp0_result,
    output logic [W-1:0] resp0_check,
    output logic [W-1:0] resp1_result,
    output logic [W-1:0] resp1_check,
    output logic         resp0_err,
    output logic         resp1_err,
    output logic [W-1:0] start_st_a,
    output logic [W-1:0] start_st_b,
    output logic         EN_start,
    input  logic         RDY_start,
    output logic [W-1:0] result_st_c,
    input  logic [W-1:0] result,
    input  logic         RDY_result,
    output logic [W-1:0] check_st_d,
    output logic         EN_check,
    input  logic [W-1:0] check,
    input  logic         RDY_check
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("design06_sched: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_START    = 2'd1,
        S_WAIT_RES = 2'd2,
        S_CHECK    = 2'd3
    } state_t;

    state_t         r_state;
    logic           r_owner;
    logic           r_prio;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_c;
    logic [W-1:0]   r_d;
    logic [W-1:0]   r_result;
    logic [1:0]     r_resp_valid;
    logic [W-1:0]   r_resp0_result;
    logic [W-1:0]   r_resp0_check;
    logic [W-1:0]   r_resp1_result;
    logic [W-1:0]   r_resp1_check;

    logic           w_elig0;
    logic           w_elig1;
    logic           w_grant0;
    logic           w_grant1;
    logic           w_idle;
    logic           w_wd_expire;

    // A client holding an unconsumed response is not eligible; prio only
    // breaks ties when both clients are eligible.
    assign w_idle   = (r_state == S_IDLE);
    assign w_elig0  = req0_valid && !r_resp_valid[0];
    assign w_elig1  = req1_valid && !r_resp_valid[1];
    assign w_grant0 = w_idle && w_elig0 && (!w_elig1 || !r_prio);
    assign w_grant1 = w_idle && w_elig1 && (!w_elig0 ||  r_prio);

    // Gated with RST_N so the pulses are low throughout reset even if a
    // client holds its request.
    assign req0_ack = RST_N && w_grant0;
    assign req1_ack = RST_N && w_grant1;

    // Completion always wins over a same-cycle watchdog expiry, so the enables
    // simply follow their ready inputs inside their state.
    assign EN_start = RST_N && (r_state == S_START) && RDY_start;
    assign EN_check = RST_N && (r_state == S_CHECK) && RDY_check;

    assign start_st_a  = r_a;
    assign start_st_b  = r_b;
    assign result_st_c = r_c;
    assign check_st_d  = r_d;

    assign resp0_valid  = r_resp_valid[0];
    assign resp1_valid  = r_resp_valid[1];
    assign resp0_result = r_resp0_result;
    assign resp0_check  = r_resp0_check;
    assign resp1_result = r_resp1_result;
    assign resp1_check  = r_resp1_check;

`ifdef DESIGN06_SCHED_WATCHDOG_EN
    logic [7:0] r_wd_cnt;
    logic [1:0] r_resp_err;

    // The counter is 0 in the first START cycle, so expiry lands in the
    // TIMEOUT-th busy cycle.
    assign w_wd_expire = (r_wd_cnt == 8'(TIMEOUT - 1));
    assign resp0_err   = r_resp_err[0];
    assign resp1_err   = r_resp_err[1];
`else
    assign w_wd_expire = 1'b0;
    assign resp0_err   = 1'b0;
    assign resp1_err   = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state        <= S_IDLE;
            r_owner        <= 1'b0;
            r_prio         <= 1'b0;
            r_a            <= '0;
            r_b            <= '0;
            r_c            <= '0;
            r_d            <= '0;
            r_result       <= '0;
            r_resp_valid   <= 2'b00;
            r_resp0_result <= '0;
            r_resp0_check  <= '0;
            r_resp1_result <= '0;
            r_resp1_check  <= '0;
`ifdef DESIGN06_SCHED_WATCHDOG_EN
            r_wd_cnt       <= 8'd0;
            r_resp_err     <= 2'b00;
`endif
        end else begin
            // The consume clears are placed first. A fill only ever targets an
            // empty slot, so a later fill below never races a valid ack.
            if (resp0_ack && r_resp_valid[0]) begin
                r_resp_valid[0] <= 1'b0;
            end
            if (resp1_ack && r_resp_valid[1]) begin
                r_resp_valid[1] <= 1'b0;
            end

`ifdef DESIGN06_SCHED_WATCHDOG_EN
            if (r_state != S_IDLE) begin
                r_wd_cnt <= r_wd_cnt + 8'd1;
            end
`endif

            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_a     <= w_grant1 ? req1_a : req0_a;
                        r_b     <= w_grant1 ? req1_b : req0_b;
                        r_c     <= w_grant1 ? req1_c : req0_c;
                        r_d     <= w_grant1 ? req1_d : req0_d;
                        r_owner <= w_grant1;
                        r_prio  <= ~w_grant1;
                        r_state <= S_START;
`ifdef DESIGN06_SCHED_WATCHDOG_EN
                        r_wd_cnt <= 8'd0;
`endif
                    end
                end

                S_START: begin
                    if (RDY_start) begin
                        r_state <= S_WAIT_RES;
                    end else if (w_wd_expire) begin
                        r_state <= S_IDLE;
                    end
                end

                S_WAIT_RES: begin
                    if (RDY_result) begin
                        r_result <= result;
                        r_state  <= S_CHECK;
                    end else if (w_wd_expire) begin
                        r_state <= S_IDLE;
                    end
                end

                S_CHECK: begin
                    if (RDY_check) begin
                        r_state <= S_IDLE;
                        if (!r_owner) begin
                            r_resp_valid[0] <= 1'b1;
                            r_resp0_result  <= r_result;
                            r_resp0_check   <= check;
                        end else begin
                            r_resp_valid[1] <= 1'b1;
                            r_resp1_result  <= r_result;
                            r_resp1_check   <= check;
                        end
`ifdef DESIGN06_SCHED_WATCHDOG_EN
                        r_resp_err[r_owner] <= 1'b0;
`endif
                    end else if (w_wd_expire) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase

`ifdef DESIGN06_SCHED_WATCHDOG_EN
            // An abort from any busy state returns an error response with zeroed data.
            if (w_wd_expire &&
                ((r_state == S_START    && !RDY_start)  ||
                 (r_state == S_WAIT_RES && !RDY_result) ||
                 (r_state == S_CHECK    && !RDY_check))) begin
                r_resp_valid[r_owner] <= 1'b1;
                r_resp_err[r_owner]   <= 1'b1;
                if (!r_owner) begin
                    r_resp0_result <= '0;
                    r_resp0_check  <= '0;
                end else begin
                    r_resp1_result <= '0;
                    r_resp1_check  <= '0;
                end
            end
`endif
        end
    end

endmodule
